serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits, at least 2.
REQ-002 SHALL have parameter DIGIT, default 1: bits added per clock cycle; must divide WIDTH exactly; STEPS = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands A, B and Cin are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port A, input, WIDTH bits: first operand.
REQ-008 SHALL have port B, input, WIDTH bits: second operand.
REQ-009 SHALL have port Cin, input, 1 bit: carry in.
REQ-010 SHALL have port out_valid, output, 1 bit: S and Cout hold a finished result.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port S, output, WIDTH bits: the sum, (A+B+Cin) mod 2^WIDTH.
REQ-013 SHALL have port Cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-014 SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-016 On a rising edge with in_valid=1 and in_ready=1, SHALL capture A, B and Cin into internal registers, clear the step counter and go to RUN.
REQ-017 Each RUN cycle SHALL add the low DIGIT bits of the A and B registers plus the carry register.
REQ-018 Each RUN cycle SHALL shift the DIGIT-bit sum into the top of the sum register and shift both operand registers right by DIGIT.
REQ-019 Each RUN cycle SHALL update the carry register and increment the counter.
REQ-020 When the counter equals STEPS-1 in RUN, SHALL go to DONE on that edge.
REQ-021 out_valid SHALL rise exactly STEPS rising edges after the accepting edge.
REQ-022 In DONE, SHALL hold out_valid=1 with S and Cout stable.
REQ-023 In DONE, a rising edge with out_ready=1 SHALL return the block to IDLE.
REQ-024 With out_ready=0, SHALL stay in DONE indefinitely with no change to S or Cout.
REQ-025 The result SHALL be consumed before a new operand is accepted (no overlap).
REQ-026 in_valid SHALL be ignored in RUN and DONE; the operand inputs may change freely during RUN.
REQ-027 out_valid SHALL be 0 in IDLE and RUN.
REQ-028 In IDLE and RUN, S and Cout SHALL hold their last values and SHALL NOT be treated as valid.
REQ-029 Carry SHALL propagate correctly across digit boundaries, including the wrap-around case: all ones plus 1 gives S=0 and Cout=1.

Reset
REQ-030 rst=1 SHALL force, without waiting for a clock edge: state IDLE, in_ready=1, out_valid=0, S=0, Cout=0, counter, carry and operand registers 0.
REQ-031 Reset in RUN or DONE SHALL abandon the operation with no result delivered.
REQ-032 The first operand accept SHALL be possible on the first rising edge after rst falls.

Configuration
REQ-033 With macro SERIAL_ADDER_OVF_EN defined, SHALL add output port OVF, 1 bit, registered: two's-complement signed overflow, i.e. the carry into bit WIDTH-1 XOR Cout.
REQ-034 OVF SHALL be valid under the same rules as Cout and SHALL reset to 0.
REQ-035 Without SERIAL_ADDER_OVF_EN, the OVF port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-036 Package serial_adder_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and a function computing STEPS and the counter width from WIDTH and DIGIT.
REQ-037 Combinational sub-module adder_digit SHALL be a DIGIT-bit ripple of full-adder cells (inputs a, b, ci; outputs s, co, and the carry into its MSB for overflow), instantiated once.

Verification
REQ-038 WIDTH=8, DIGIT=1, A=8'hFF, B=8'h01, Cin=0 -> out_valid 8 edges after accept; S=8'h00, Cout=1.
REQ-039 WIDTH=8, DIGIT=4, A=8'h5A, B=8'h3C, Cin=1 -> out_valid 2 edges after accept; S=8'h97, Cout=0.
REQ-040 Macro defined, WIDTH=8, A=8'h7F, B=8'h01, Cin=0 -> S=8'h80, Cout=0, OVF=1; A=8'h80, B=8'h80 -> S=8'h00, Cout=1, OVF=1.
REQ-041 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> S, Cout and out_valid stable, in_ready=0, no accept.
REQ-042 Raise out_ready -> IDLE next edge, then a new operand is accepted.
REQ-043 Assert rst for 1 ns midway through RUN (DIGIT=1, step 3) -> outputs 0 immediately and in_ready=1.
REQ-044 Next operand after that reset, A=8'h03, B=8'h04, Cin=0 -> S=8'h07, Cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] steps;
    logic [31:0] cnt_w;
  } step_cfg_t;

  // Number of digit steps and the counter width needed to count them (never below 1 bit).
  function automatic step_cfg_t step_cfg(input int width, input int digit);
    step_cfg_t cfg;
    int        steps;
    steps     = width / digit;
    cfg.steps = 32'(steps);
    cfg.cnt_w = (steps > 1) ? 32'($clog2(steps)) : 32'd1;
    return cfg;
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// DIGIT-bit ripple-carry slice; also exposes the carry into its MSB for signed overflow.
module adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder with valid/ready handshakes, DIGIT bits per clock.
// Optional signed-overflow output OVF is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam step_cfg_t CFG   = step_cfg(WIDTH, DIGIT);
  localparam int        STEPS = int'(CFG.steps);
  localparam int        CNT_W = int'(CFG.cnt_w);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg, s_reg;
  logic               carry_reg, cout_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [DIGIT-1:0]   dig_s;
  logic               dig_co;
  logic [WIDTH-1:0]   sum_shift;
  logic               accept, last_step;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;
  assign last_step = (state_reg == RUN) && (cnt_reg == CNT_W'(STEPS - 1));
  assign S         = s_reg;
  assign Cout      = cout_reg;

`ifdef SERIAL_ADDER_OVF_EN
  logic dig_cmsb;
`endif

  adder_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (a_reg[DIGIT-1:0]),
    .b    (b_reg[DIGIT-1:0]),
    .ci   (carry_reg),
    .s    (dig_s),
    .co   (dig_co),
`ifdef SERIAL_ADDER_OVF_EN
    .cmsb (dig_cmsb)
`else
    .cmsb ()
`endif
  );

  // New digit enters at the top so after STEPS shifts the LSB digit lands at bit 0.
  generate
    if (STEPS > 1) begin : g_shift
      assign sum_shift = {dig_s, sum_reg[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign sum_shift = dig_s;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= B;
      sum_reg   <= '0;
      carry_reg <= Cin;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> DIGIT;
      b_reg     <= b_reg >> DIGIT;
      sum_reg   <= sum_shift;
      carry_reg <= dig_co;
      cnt_reg   <= cnt_reg + CNT_W'(1);
      // Visible result only changes on the final step, so S/Cout hold outside DONE.
      if (last_step) begin
        s_reg    <= sum_shift;
        cout_reg <= dig_co;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (last_step) begin
      ovf_reg <= dig_cmsb ^ dig_co;
    end
  end

  assign OVF = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench: a 1-bit-digit and a 4-bit-digit instance run side by side
// against an arithmetic reference model.
`timescale 1ns/100ps
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       Cin = 1'b0;

  logic       in_ready1, out_valid1, cout1;
  logic       in_ready4, out_valid4, cout4;
  logic [7:0] s1, s4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf1, ovf4;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .A(A), .B(B), .Cin(Cin), .out_valid(out_valid1), .out_ready(out_ready),
    .S(s1), .Cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .OVF(ovf1)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .A(A), .B(B), .Cin(Cin), .out_valid(out_valid4), .out_ready(out_ready),
    .S(s4), .Cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .OVF(ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
    logic [8:0] tot;
    logic [7:0] es;
    logic       ec, eo;
    int         n, lat1, lat4;
    tot = {1'b0, a} + {1'b0, b} + {8'b0, c};
    es  = tot[7:0];
    ec  = tot[8];
    eo  = (a[7] == b[7]) && (es[7] != a[7]);
    chk("idle_ready_d1", 32'(in_ready1), 32'd1);
    chk("idle_ready_d4", 32'(in_ready4), 32'd1);
    in_valid = 1'b1;
    A = a; B = b; Cin = c;
    @(posedge clk); #1;
    chk("run_ready_d1", 32'(in_ready1), 32'd0);
    n = 0; lat1 = 0; lat4 = 0;
    while ((lat1 == 0 || lat4 == 0) && n < 20) begin
      A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
      @(posedge clk); #1;
      n++;
      if (out_valid1 && lat1 == 0) lat1 = n;
      if (out_valid4 && lat4 == 0) lat4 = n;
    end
    chk("latency_d1", 32'(lat1), 32'd8);
    chk("latency_d4", 32'(lat4), 32'd2);
    chk("sum_d1", 32'(s1), 32'(es));
    chk("cout_d1", 32'(cout1), 32'(ec));
    chk("sum_d4", 32'(s4), 32'(es));
    chk("cout_d4", 32'(cout4), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_d1", 32'(ovf1), 32'(eo));
    chk("ovf_d4", 32'(ovf4), 32'(eo));
`endif
    $display("op A=%02h B=%02h Cin=%0d -> d1 S=%02h C=%0d, d4 S=%02h C=%0d (exp S=%02h C=%0d V=%0d)",
             a, b, c, s1, cout1, s4, cout4, es, ec, eo);
    for (int k = 0; k < hold; k++) begin
      A = 8'($urandom); B = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_valid_d1", 32'(out_valid1), 32'd1);
      chk("hold_ready_d1", 32'(in_ready1), 32'd0);
      chk("hold_sum_d1", 32'(s1), 32'(es));
      chk("hold_cout_d4", 32'(cout4), 32'(ec));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid_d1", 32'(out_valid1), 32'd0);
    chk("drain_valid_d4", 32'(out_valid4), 32'd0);
    chk("idle_sum_d1", 32'(s1), 32'(es));
  endtask

  initial begin
    #2;
    chk("rst_ready_d1", 32'(in_ready1), 32'd1);
    chk("rst_valid_d1", 32'(out_valid1), 32'd0);
    chk("rst_sum_d1", 32'(s1), 32'd0);
    chk("rst_cout_d4", 32'(cout4), 32'd0);
    #11 rst = 1'b0;

    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h5A, 8'h3C, 1'b1, 5);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 1);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    run_op(8'h12, 8'h34, 1'b0, 0);
    in_valid = 1'b1;
    A = 8'hAB; B = 8'h11; Cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #0.5;
    chk("abort_valid_d1", 32'(out_valid1), 32'd0);
    chk("abort_ready_d1", 32'(in_ready1), 32'd1);
    chk("abort_sum_d1", 32'(s1), 32'd0);
    chk("abort_sum_d4", 32'(s4), 32'd0);
    chk("abort_valid_d4", 32'(out_valid4), 32'd0);
    #0.5 rst = 1'b0;
    run_op(8'h03, 8'h04, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
